// File: rtl/clock_display_scan_if.sv
// Digit/display bundle between the hour/minute generators, the scan block
// and the seven-segment display. Master drives the BCD digits and set key;
// slave (the scan block) drives segments, anodes, colon and frame tick.
interface clock_display_scan_if;
    logic [3:0] h1;
    logic [3:0] h2;
    logic [3:0] m1;
    logic [3:0] m2;
    logic       key;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    modport master (
        output h1, h2, m1, m2, key,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  h1, h2, m1, m2, key,
        output seg, dp, an, frame_tick
    );
endinterface

// File: rtl/clock_display_scan.sv
// Four-digit multiplexed common-anode display scanner for HH:MM.
// Digits are snapshotted once per frame so a rollover is never shown torn;
// a leading hour zero is blanked, the colon blinks, and the hour digits
// blink while the set key is held low.
module clock_display_scan #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    clock_display_scan_if.slave  bus
);

    localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FC_LAST = FW'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Scan timing state
    logic [PW-1:0] pQ, pD;
    logic [1:0]    idxQ, idxD;
    logic [FW-1:0] fcQ, fcD;
    logic          blinkQ, blinkD;

    // Frame snapshot of {h1,h2,m1,m2}
    logic [15:0]   snapQ, snapD;
    logic          primedQ, primedD;

    // Registered display outputs
    logic [6:0]    segQ, segD;
    logic [3:0]    anQ, anD;
    logic          dpQ, dpD;
    logic          tickQ, tickD;

    logic          slotEnd;
    logic          frameWrap;
    logic [3:0]    digit;

    // Active-low seven-segment pattern {g,f,e,d,c,b,a}; non-BCD shows a dash
    function automatic logic [6:0] decodeDigit(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b0111111;
        endcase
        return pattern;
    endfunction

    // Prescaler, slot index, frame counter and blink phase next state
    always_comb begin
        slotEnd   = (pQ == P_LAST);
        frameWrap = slotEnd && (idxQ == 2'd3);

        pD     = slotEnd ? '0 : pQ + PW'(1);
        idxD   = slotEnd ? idxQ + 2'd1 : idxQ;
        fcD    = fcQ;
        blinkD = blinkQ;
        tickD  = frameWrap;

        if (frameWrap) begin
            if (fcQ == FC_LAST) begin
                fcD    = '0;
                blinkD = ~blinkQ;
            end else begin
                fcD = fcQ + FW'(1);
            end
        end
    end

    // Snapshot loads once right after reset, then only at the frame wrap
    always_comb begin
        snapD   = snapQ;
        primedD = 1'b1;
        if (!primedQ || frameWrap) begin
            snapD = {bus.h1, bus.h2, bus.m1, bus.m2};
        end
    end

    // Anode, segment and colon values for the slot currently indexed
    always_comb begin
        digit = 4'd0;
        anD   = 4'b1111;
        case (idxQ)
            2'd0: begin digit = snapQ[15:12]; anD = 4'b0111; end
            2'd1: begin digit = snapQ[11:8];  anD = 4'b1011; end
            2'd2: begin digit = snapQ[7:4];   anD = 4'b1101; end
            default: begin digit = snapQ[3:0]; anD = 4'b1110; end
        endcase

        if (!bus.key && !blinkQ && !idxQ[1]) begin
            segD = SEG_BLANK;
        end else if ((idxQ == 2'd0) && (snapQ[15:12] == 4'd0)) begin
            segD = SEG_BLANK;
        end else begin
            segD = decodeDigit(digit);
        end

        dpD = !((idxQ == 2'd1) && blinkQ);
    end

    // All state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pQ      <= '0;
            idxQ    <= 2'd0;
            fcQ     <= '0;
            blinkQ  <= 1'b0;
            snapQ   <= 16'h0000;
            primedQ <= 1'b0;
            segQ    <= SEG_BLANK;
            anQ     <= 4'b1111;
            dpQ     <= 1'b1;
            tickQ   <= 1'b0;
        end else begin
            pQ      <= pD;
            idxQ    <= idxD;
            fcQ     <= fcD;
            blinkQ  <= blinkD;
            snapQ   <= snapD;
            primedQ <= primedD;
            segQ    <= segD;
            anQ     <= anD;
            dpQ     <= dpD;
            tickQ   <= tickD;
        end
    end

    assign bus.seg        = segQ;
    assign bus.an         = anQ;
    assign bus.dp         = dpQ;
    assign bus.frame_tick = tickQ;

endmodule
